seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The module SHALL have parameter W, default 8, meaning operand/result width in bits (W >= 2).
REQ-002 The module SHALL have parameter DIV_PIPE, default 1, meaning 1 = iterative W-cycle divider, 0 = single-cycle combinational divider.
REQ-003 The module SHALL have port clk  input  1  rising-edge clock.
REQ-004 The module SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The module SHALL have port in_valid  input  1  request present.
REQ-006 The module SHALL have port in_ready  output  1  module accepts request this cycle.
REQ-007 The module SHALL have port opcode  input  4  0=PUSH 1=POP 2=ADD 3=MUL 4=SUB 5=DIV 6=REM; bit3 = upstream error marker.
REQ-008 The module SHALL have port op_a  input  W  first-popped operand (minuend/dividend).
REQ-009 The module SHALL have port op_b  input  W  second-popped operand (subtrahend/divisor).
REQ-010 The module SHALL have port push_val  input  W  literal for PUSH.
REQ-011 The module SHALL have port out_valid  output  1  response present.
REQ-012 The module SHALL have port out_ready  input  1  consumer accepts response.
REQ-013 The module SHALL have port result  output  W  response value.
REQ-014 The module SHALL have port queue_op  output  2  00=PUSH 01=SLEEP 11=POP 10=GET_AND_PUSH.
REQ-015 The module SHALL have port ovf  output  1  ADD carry / SUB borrow / MUL high half nonzero.
REQ-016 The module SHALL have port err  output  1  error for the current response.
REQ-017 The module SHALL have port err_code  output  2  00=none 01=divide-by-zero 10=illegal opcode.
REQ-018 The module SHALL have port err_sticky  output  1  OR of all err since reset.

Function
REQ-019 FSM states SHALL be IDLE, BUSY (divider iterating) and HOLD (response waiting); handshake occurs when valid and ready are both 1 on a rising edge.
REQ-020 in_ready SHALL be 1 only in IDLE, or in HOLD while out_ready is 1 (back-to-back acceptance).
REQ-021 Non-divide requests and all error cases SHALL register the response and enter HOLD with out_valid=1 one cycle after acceptance.
REQ-022 PUSH SHALL give result=push_val, queue_op=00; POP SHALL give result=0, queue_op=11; both with ovf=0.
REQ-023 ADD SHALL give result=(a+b) mod 2^W, ovf=carry out; SUB SHALL give result=(a-b) mod 2^W, ovf=1 iff a<b (unsigned); MUL SHALL give result=low W bits of the product, ovf=1 iff the high W bits are nonzero; all three with queue_op=10.
REQ-024 DIV/REM with b!=0 SHALL give unsigned a/b or a%b with queue_op=10 and ovf=0; with DIV_PIPE=1 they SHALL enter BUSY for exactly W cycles of restoring division and then HOLD, so out_valid rises W+1 cycles after acceptance.
REQ-025 DIV/REM with b=0 SHALL give a 1-cycle response: result=0, queue_op=01, err=1, err_code=01.
REQ-026 Opcodes 7..15 SHALL give result=0 and queue_op=01; when opcode[3]=0 they SHALL also set err=1 and err_code=10, otherwise err=0.
REQ-027 While out_valid=1 and out_ready=0, result, queue_op, ovf, err and err_code SHALL remain stable.
REQ-028 HOLD SHALL return to IDLE on out_ready unless a new request is accepted in the same cycle.
REQ-029 err_sticky SHALL set on the cycle err first asserts with out_valid=1 and SHALL clear only on rst.
REQ-030 In BUSY, in_valid SHALL be ignored and the inputs need not be held stable, because operands are captured at acceptance.

Reset
REQ-031 While rst=1 at a clock edge, state SHALL become IDLE and out_valid, result, queue_op(=01), ovf, err, err_code and err_sticky SHALL all be 0 except queue_op.
REQ-032 rst asserted in BUSY or HOLD SHALL abort the operation and discard the pending response with no out_valid pulse.
REQ-033 in_ready SHALL be 0 during the rst cycle and 1 in the first cycle after rst deasserts.

Verification
REQ-034 W=8, ADD a=200 b=100 -> one cycle later: out_valid=1, result=44, ovf=1, queue_op=10.
REQ-035 W=8, DIV_PIPE=1, DIV a=100 b=7 -> out_valid after 9 cycles, result=14; REM with the same operands -> result=2; in_ready=0 throughout BUSY.
REQ-036 DIV a=5 b=0 -> one cycle later: result=0, err=1, err_code=01, queue_op=01, err_sticky=1 and remaining 1 until rst.
REQ-037 Opcode 4'b0111 -> err=1, err_code=10; opcode 4'b1010 -> err=0, queue_op=01.
REQ-038 out_ready held at 0 for 5 cycles after a MUL a=16 b=17 -> result stays 16, ovf stays 1 for all 5 cycles; then out_ready=1 with in_valid=1 -> new request accepted in that same cycle.
REQ-039 rst pulsed at cycle 3 of a DIV -> out_valid never asserts for it, and the next SUB a=3 b=5 gives result=254, ovf=1.

Source files
------------

// File: rtl/seq_alu.sv
// Sequential stack-machine ALU: accepts one request at a time, answers through a
// valid/ready response port, and optionally divides with a W-cycle restoring divider.
module seq_alu #(
    parameter int unsigned W        = 8,
    parameter int unsigned DIV_PIPE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   opcode,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic [W-1:0] push_val,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic [1:0]   queue_op,
    output logic         ovf,
    output logic         err,
    output logic [1:0]   err_code,
    output logic         err_sticky
);

    localparam int unsigned CntW = $clog2(W);
    localparam logic [CntW-1:0] CntLast = CntW'(W - 1);

    localparam logic [1:0] QPush  = 2'b00;
    localparam logic [1:0] QSleep = 2'b01;
    localparam logic [1:0] QPop   = 2'b11;
    localparam logic [1:0] QGetPush = 2'b10;

    typedef enum logic [1:0] {StIdle, StBusy, StHold} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    result_q, result_d;
    logic [1:0]      queue_op_q, queue_op_d;
    logic            ovf_q, ovf_d;
    logic            err_q, err_d;
    logic [1:0]      err_code_q, err_code_d;
    logic            err_sticky_q, err_sticky_d;
    // Divider working set: quotient/dividend shift register, partial remainder, divisor.
    logic [W-1:0]    quo_q, quo_d;
    logic [W-1:0]    rem_q, rem_d;
    logic [W-1:0]    dvs_q, dvs_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            is_rem_q, is_rem_d;

    logic            accept;
    logic [W-1:0]    req_result;
    logic [1:0]      req_queue_op;
    logic            req_ovf;
    logic            req_err;
    logic [1:0]      req_err_code;
    logic            req_iter;
    logic [W:0]      sum;
    logic [2*W-1:0]  prod;
    logic [W:0]      rem_sh;
    logic [W-1:0]    rem_nxt;
    logic [W-1:0]    quo_nxt;

    // Decode the incoming request into its single-cycle response (or a divider start).
    always_comb begin
        req_result   = '0;
        req_queue_op = QSleep;
        req_ovf      = 1'b0;
        req_err      = 1'b0;
        req_err_code = 2'b00;
        req_iter     = 1'b0;
        sum          = {1'b0, op_a} + {1'b0, op_b};
        prod         = {{W{1'b0}}, op_a} * {{W{1'b0}}, op_b};
        case (opcode)
            4'd0: begin
                req_result   = push_val;
                req_queue_op = QPush;
            end
            4'd1: begin
                req_queue_op = QPop;
            end
            4'd2: begin
                req_result   = sum[W-1:0];
                req_ovf      = sum[W];
                req_queue_op = QGetPush;
            end
            4'd3: begin
                req_result   = prod[W-1:0];
                req_ovf      = |prod[2*W-1:W];
                req_queue_op = QGetPush;
            end
            4'd4: begin
                req_result   = op_a - op_b;
                req_ovf      = op_a < op_b;
                req_queue_op = QGetPush;
            end
            4'd5, 4'd6: begin
                if (op_b == '0) begin
                    req_err      = 1'b1;
                    req_err_code = 2'b01;
                end else if (DIV_PIPE != 0) begin
                    req_iter = 1'b1;
                end else begin
                    req_result   = (opcode == 4'd5) ? op_a / op_b : op_a % op_b;
                    req_queue_op = QGetPush;
                end
            end
            default: begin
                // Bit 3 marks an error already reported upstream; don't double-flag it.
                req_err      = ~opcode[3];
                req_err_code = opcode[3] ? 2'b00 : 2'b10;
            end
        endcase
    end

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_sh = {rem_q, quo_q[W-1]};
        if (rem_sh >= {1'b0, dvs_q}) begin
            rem_nxt = rem_sh[W-1:0] - dvs_q;
            quo_nxt = {quo_q[W-2:0], 1'b1};
        end else begin
            rem_nxt = rem_sh[W-1:0];
            quo_nxt = {quo_q[W-2:0], 1'b0};
        end
    end

    // Next-state logic for the FSM, response registers and divider.
    always_comb begin
        state_d      = state_q;
        result_d     = result_q;
        queue_op_d   = queue_op_q;
        ovf_d        = ovf_q;
        err_d        = err_q;
        err_code_d   = err_code_q;
        err_sticky_d = err_sticky_q;
        quo_d        = quo_q;
        rem_d        = rem_q;
        dvs_d        = dvs_q;
        cnt_d        = cnt_q;
        is_rem_d     = is_rem_q;

        in_ready = ~rst & ((state_q == StIdle) | ((state_q == StHold) & out_ready));
        accept   = in_valid & in_ready;

        unique case (state_q)
            StIdle: ;
            StBusy: begin
                quo_d = quo_nxt;
                rem_d = rem_nxt;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    state_d    = StHold;
                    result_d   = is_rem_q ? rem_nxt : quo_nxt;
                    queue_op_d = QGetPush;
                    ovf_d      = 1'b0;
                    err_d      = 1'b0;
                    err_code_d = 2'b00;
                end
            end
            StHold: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Acceptance only happens in IDLE or HOLD, so it overrides the HOLD exit.
        if (accept) begin
            if (req_iter) begin
                state_d  = StBusy;
                quo_d    = op_a;
                rem_d    = '0;
                dvs_d    = op_b;
                cnt_d    = '0;
                is_rem_d = (opcode == 4'd6);
            end else begin
                state_d      = StHold;
                result_d     = req_result;
                queue_op_d   = req_queue_op;
                ovf_d        = req_ovf;
                err_d        = req_err;
                err_code_d   = req_err_code;
                err_sticky_d = err_sticky_q | req_err;
            end
        end
    end

    // State and response registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            result_q     <= '0;
            queue_op_q   <= QSleep;
            ovf_q        <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= 2'b00;
            err_sticky_q <= 1'b0;
            quo_q        <= '0;
            rem_q        <= '0;
            dvs_q        <= '0;
            cnt_q        <= '0;
            is_rem_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            result_q     <= result_d;
            queue_op_q   <= queue_op_d;
            ovf_q        <= ovf_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            err_sticky_q <= err_sticky_d;
            quo_q        <= quo_d;
            rem_q        <= rem_d;
            dvs_q        <= dvs_d;
            cnt_q        <= cnt_d;
            is_rem_q     <= is_rem_d;
        end
    end

    assign out_valid  = (state_q == StHold);
    assign result     = result_q;
    assign queue_op   = queue_op_q;
    assign ovf        = ovf_q;
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu (W=8, iterative divider): spec-level model plus directed vectors.
module tb_seq_alu;

    localparam int unsigned W = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] opcode;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [7:0] push_val;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic [1:0] queue_op;
    logic       ovf;
    logic       err;
    logic [1:0] err_code;
    logic       err_sticky;

    int checks = 0;
    int errors = 0;

    seq_alu #(.W(W), .DIV_PIPE(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .op_a       (op_a),
        .op_b       (op_b),
        .push_val   (push_val),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .queue_op   (queue_op),
        .ovf        (ovf),
        .err        (err),
        .err_code   (err_code),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [7:0] res;
        logic [1:0] qop;
        logic       ovf;
        logic       err;
        logic [1:0] code;
    } resp_t;

    function automatic resp_t model_resp(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic [7:0] pv);
        resp_t r;
        int    ia = int'(a);
        int    ib = int'(b);
        int    t;
        r = '{res: 8'd0, qop: 2'b01, ovf: 1'b0, err: 1'b0, code: 2'b00};
        case (op)
            4'd0: begin r.res = pv; r.qop = 2'b00; end
            4'd1: r.qop = 2'b11;
            4'd2: begin t = ia + ib; r.res = 8'(t % 256); r.ovf = (t > 255); r.qop = 2'b10; end
            4'd3: begin t = ia * ib; r.res = 8'(t % 256); r.ovf = (t > 255); r.qop = 2'b10; end
            4'd4: begin t = ia - ib + 256; r.res = 8'(t % 256); r.ovf = (ia < ib); r.qop = 2'b10; end
            4'd5, 4'd6: begin
                if (ib == 0) begin
                    r.err = 1'b1; r.code = 2'b01;
                end else begin
                    r.res = 8'((op == 4'd5) ? ia / ib : ia % ib);
                    r.qop = 2'b10;
                end
            end
            default: begin
                r.err  = (op < 4'd8);
                r.code = (op < 4'd8) ? 2'b10 : 2'b00;
            end
        endcase
        return r;
    endfunction

    function automatic logic is_long(input logic [3:0] op, input logic [7:0] b);
        return (op == 4'd5 || op == 4'd6) && (b != 8'd0);
    endfunction

    function automatic logic resp_err(input logic [3:0] op, input logic [7:0] b);
        resp_t r;
        r = model_resp(op, 8'd0, b, 8'd0);
        return r.err;
    endfunction

    logic  m_valid  = 1'b0;
    int    m_wait   = 0;     // cycles until a long division finishes
    logic  m_fresh  = 1'b0;  // fields still hold reset values
    logic  m_sticky = 1'b0;
    resp_t m_cur    = '0;
    resp_t m_pend   = '0;

    // Model update on each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            m_valid  <= 1'b0;
            m_wait   <= 0;
            m_fresh  <= 1'b1;
            m_sticky <= 1'b0;
            m_cur    <= '{res: 8'd0, qop: 2'b01, ovf: 1'b0, err: 1'b0, code: 2'b00};
        end else if (m_wait != 0) begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) begin
                m_cur   <= m_pend;
                m_valid <= 1'b1;
            end
        end else if (in_valid && (!m_valid || out_ready)) begin
            m_fresh <= 1'b0;
            if (is_long(opcode, op_b)) begin
                m_pend  <= model_resp(opcode, op_a, op_b, push_val);
                m_wait  <= W;
                m_valid <= 1'b0;
            end else begin
                m_cur    <= model_resp(opcode, op_a, op_b, push_val);
                m_valid  <= 1'b1;
                m_sticky <= m_sticky | resp_err(opcode, op_b);
            end
        end else if (m_valid && out_ready) begin
            m_valid <= 1'b0;
        end
    end

    // Compare DUT against the model mid-cycle.
    always @(negedge clk) begin
        check("in_ready", 32'(in_ready),
              32'(!rst && ((!m_valid && m_wait == 0) || (m_valid && out_ready))));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("err_sticky", 32'(err_sticky), 32'(m_sticky));
        if (m_valid || m_fresh) begin
            check("result", 32'(result), 32'(m_cur.res));
            check("queue_op", 32'(queue_op), 32'(m_cur.qop));
            check("ovf", 32'(ovf), 32'(m_cur.ovf));
            check("err", 32'(err), 32'(m_cur.err));
            check("err_code", 32'(err_code), 32'(m_cur.code));
        end
    end

    // ---------------- stimulus ----------------
    // Present a request, wait (bounded) for acceptance, then scramble the inputs.
    task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] pv);
        bit ok = 1'b0;
        in_valid = 1'b1; opcode = op; op_a = a; op_b = b; push_val = pv;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL accept_timeout actual=no_ready expected=ready op=%0d", op);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        opcode = 4'($urandom); op_a = 8'($urandom); op_b = 8'($urandom);
        push_val = 8'($urandom);
    endtask

    task automatic wait_resp();
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL resp_timeout actual=no_valid expected=valid");
        end
        @(posedge clk); #1;
    endtask

    // Busy for exactly 8 cycles with in_ready low, then the expected value.
    task automatic div_expect(input logic [7:0] exp);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("div_busy_valid", 32'(out_valid), 32'd0);
            check("div_busy_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        check("div_valid", 32'(out_valid), 32'd1);
        check("div_result", 32'(result), 32'(exp));
        check("div_qop", 32'(queue_op), 32'd2);
        @(posedge clk); #1;
    endtask

    localparam int N = 15;
    logic [3:0] t_op [N] = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd4, 4'd4, 4'd3, 4'd3, 4'd5, 4'd6,
                             4'd5, 4'd9, 4'd15, 4'd8, 4'd12};
    logic [7:0] t_a  [N] = '{8'd0, 8'd0, 8'd255, 8'd10, 8'd5, 8'd0, 8'd15, 8'd255, 8'd255,
                             8'd7, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4};
    logic [7:0] t_b  [N] = '{8'd0, 8'd0, 8'd1, 8'd20, 8'd3, 8'd0, 8'd15, 8'd255, 8'd1,
                             8'd9, 8'd3, 8'd1, 8'd2, 8'd3, 8'd4};

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        opcode = 4'd0; op_a = 8'd0; op_b = 8'd0; push_val = 8'd0;

        // Reset state
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_queue_op", 32'(queue_op), 32'd1);
        check("rst_result", 32'(result), 32'd0);
        check("rst_sticky", 32'(err_sticky), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // ADD 200+100
        send(4'd2, 8'd200, 8'd100, 8'd0);
        @(negedge clk);
        check("add_valid", 32'(out_valid), 32'd1);
        check("add_result", 32'(result), 32'd44);
        check("add_ovf", 32'(ovf), 32'd1);
        check("add_qop", 32'(queue_op), 32'd2);
        @(posedge clk); #1;

        // DIV / REM 100,7
        send(4'd5, 8'd100, 8'd7, 8'd0);
        div_expect(8'd14);
        send(4'd6, 8'd100, 8'd7, 8'd0);
        div_expect(8'd2);

        // Divide by zero
        send(4'd5, 8'd5, 8'd0, 8'd0);
        @(negedge clk);
        check("dz_result", 32'(result), 32'd0);
        check("dz_err", 32'(err), 32'd1);
        check("dz_code", 32'(err_code), 32'd1);
        check("dz_qop", 32'(queue_op), 32'd1);
        check("dz_sticky", 32'(err_sticky), 32'd1);
        @(posedge clk); #1;

        // Illegal opcodes, with and without upstream marker
        send(4'd7, 8'd1, 8'd1, 8'd0);
        @(negedge clk);
        check("ill7_err", 32'(err), 32'd1);
        check("ill7_code", 32'(err_code), 32'd2);
        @(posedge clk); #1;
        send(4'd10, 8'd1, 8'd1, 8'd0);
        @(negedge clk);
        check("ill10_err", 32'(err), 32'd0);
        check("ill10_qop", 32'(queue_op), 32'd1);
        @(posedge clk); #1;

        // Table of mixed requests, checked by the model
        for (int i = 0; i < N; i++) begin
            send(t_op[i], t_a[i], t_b[i], 8'hab);
            wait_resp();
        end

        // Back-pressure: response must hold, then back-to-back acceptance
        out_ready = 1'b0;
        send(4'd3, 8'd16, 8'd17, 8'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("mul_hold_valid", 32'(out_valid), 32'd1);
            check("mul_hold_result", 32'(result), 32'd16);
            check("mul_hold_ovf", 32'(ovf), 32'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(4'd2, 8'd1, 8'd2, 8'd0);
        @(negedge clk);
        check("b2b_valid", 32'(out_valid), 32'd1);
        check("b2b_result", 32'(result), 32'd3);
        check("sticky_kept", 32'(err_sticky), 32'd1);
        @(posedge clk); #1;

        // Reset during a division discards it
        send(4'd5, 8'd100, 8'd7, 8'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("abort_no_valid", 32'(out_valid), 32'd0);
        end
        check("abort_sticky_clr", 32'(err_sticky), 32'd0);
        @(posedge clk); #1;
        send(4'd4, 8'd3, 8'd5, 8'd0);
        @(negedge clk);
        check("sub_result", 32'(result), 32'd254);
        check("sub_ovf", 32'(ovf), 32'd1);
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
